// File: rtl/mig_app_model.sv
// Behavioural stand-in for the MIG 7-series app_* user interface, backed by on-chip 128-bit memory.
// Optional handshake stalls: define MIG_MODEL_RDY_STALL_EN to gate the readies with an LFSR.
module mig_app_model #(
    parameter int DEPTH_LOG2   = 10,
    parameter int CALIB_CYCLES = 16,
    parameter int RD_LATENCY   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [26:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    input  logic [127:0] app_wdf_data,
    input  logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_rdy,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         ui_clk_sync_rst,
    output logic         init_calib_complete
);

    localparam int         CW       = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0] CMD_WR   = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WPEND = 1'b1;

    logic [127:0]            mem [0:(1<<DEPTH_LOG2)-1];
    logic [CW-1:0]           calib_cnt;
    logic                    calib;
    logic [0:0]              state;
    logic [DEPTH_LOG2-1:0]   pend_idx;
    logic [DEPTH_LOG2-1:0]   cmd_idx;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [127:0]            fifo_data [0:1];
    logic [15:0]             fifo_mask [0:1];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_cnt;
    logic [RD_LATENCY:0]     vld_pipe;
    logic [127:0]            rd_word;
    logic [127:0]            dat_pipe [1:RD_LATENCY];
    logic                    stall_cmd, stall_wdf;
    logic                    cmd_acc, wdf_push, fifo_empty, data_avail;
    logic                    rd_issue, commit, wpend_enter, fifo_pop, fifo_wr;
    logic [127:0]            wr_data;
    logic [15:0]             wr_mask;
    logic                    unused_bits;

    assign unused_bits = ^{app_wdf_end, app_addr[3:0], app_addr[26:DEPTH_LOG2+4]};

`ifdef MIG_MODEL_RDY_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr <= 16'hACE1;
        else if (calib)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall_cmd = lfsr[0];
    assign stall_wdf = lfsr[1];
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    assign cmd_idx     = app_addr[DEPTH_LOG2+3:4];
    assign app_rdy     = calib && !stall_cmd && (state == ST_IDLE);
    assign app_wdf_rdy = calib && !stall_wdf && (fifo_cnt < 2'd2);
    assign cmd_acc     = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;
    assign fifo_empty  = (fifo_cnt == 2'd0);
    assign data_avail  = !fifo_empty || wdf_push;
    assign rd_issue    = cmd_acc && (app_cmd == CMD_RD);
    assign commit      = data_avail && ((state == ST_WPEND) || (cmd_acc && app_cmd == CMD_WR));
    assign wpend_enter = cmd_acc && (app_cmd == CMD_WR) && !data_avail;
    // With an empty FIFO the incoming beat bypasses storage and commits directly.
    assign fifo_pop    = commit && !fifo_empty;
    assign fifo_wr     = wdf_push && !(commit && fifo_empty);
    assign wr_idx      = (state == ST_WPEND) ? pend_idx : cmd_idx;
    assign wr_data     = fifo_empty ? app_wdf_data : fifo_data[rd_ptr];
    assign wr_mask     = fifo_empty ? app_wdf_mask : fifo_mask[rd_ptr];

    always_ff @(posedge clk_i) begin
        ui_clk_sync_rst <= rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            calib_cnt <= CW'(CALIB_CYCLES);
            calib     <= 1'b0;
        end else begin
            if (calib_cnt != '0)
                calib_cnt <= calib_cnt - CW'(1);
            if (calib_cnt == CW'(1))
                calib <= 1'b1;
        end
    end
    assign init_calib_complete = calib;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            pend_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: if (wpend_enter) begin
                    state    <= ST_WPEND;
                    pend_idx <= cmd_idx;
                end
                ST_WPEND: if (commit) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_wr)  wr_ptr <= ~wr_ptr;
            if (fifo_pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(fifo_wr) - 2'(fifo_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_wr && !rst_i) begin
            fifo_data[wr_ptr] <= app_wdf_data;
            fifo_mask[wr_ptr] <= app_wdf_mask;
        end
    end

    // Byte-lane masked commit; a read never shares a cycle with a commit.
    always_ff @(posedge clk_i) begin
        if (commit && !rst_i) begin
            for (int b = 0; b < 16; b++)
                if (!wr_mask[b])
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (rd_issue)
            rd_word <= mem[cmd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            for (int k = 1; k <= RD_LATENCY; k++)
                dat_pipe[k] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[RD_LATENCY-1:0], rd_issue};
            dat_pipe[1] <= rd_word;
            for (int k = 2; k <= RD_LATENCY; k++)
                dat_pipe[k] <= dat_pipe[k-1];
        end
    end

    assign app_rd_data       = dat_pipe[RD_LATENCY];
    assign app_rd_data_valid = vld_pipe[RD_LATENCY];
    assign app_rd_data_end   = vld_pipe[RD_LATENCY];

endmodule
